// File: rtl/int_ctrl.sv
// Machine-mode trap sequencer: detects ECALL/EBREAK/MRET and enabled external interrupts,
// writes mepc/mcause/mstatus over a dedicated CSR port, then pulses the redirect target to ex.
module int_ctrl #(
    parameter int          INT_NUM     = 8,
    parameter logic [11:0] CSR_MSTATUS = 12'h300,
    parameter logic [11:0] CSR_MEPC    = 12'h341,
    parameter logic [11:0] CSR_MCAUSE  = 12'h342
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INT_NUM-1:0] int_flag_i,
    input  logic [31:0]        inst_i,
    input  logic [31:0]        inst_addr_i,
    input  logic               jump_flag_i,
    input  logic [31:0]        jump_addr_i,
    input  logic               ex_busy_i,
    input  logic [31:0]        csr_mtvec_i,
    input  logic [31:0]        csr_mepc_i,
    input  logic [31:0]        csr_mstatus_i,
    output logic               hold_flag_o,
    output logic               we_o,
    output logic [11:0]        waddr_o,
    output logic [31:0]        data_o,
    output logic               int_assert_o,
    output logic [31:0]        int_addr_o
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_W_MEPC    = 3'd1;
    localparam logic [2:0] S_W_MCAUSE  = 3'd2;
    localparam logic [2:0] S_W_MSTATUS = 3'd3;
    localparam logic [2:0] S_R_MSTATUS = 3'd4;
    localparam logic [2:0] S_ASSERT    = 3'd5;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;
    localparam logic [31:0] CAUSE_EXT    = 32'h8000_0010;

    // Trap entry: MPIE takes the old MIE, MIE is cleared.
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] ms);
        logic [31:0] r;
        r    = ms;
        r[7] = ms[3];
        r[3] = 1'b0;
        return r;
    endfunction

    // Trap return: MIE restored from MPIE, MPIE set.
    function automatic logic [31:0] mstatus_on_ret(input logic [31:0] ms);
        logic [31:0] r;
        r    = ms;
        r[3] = ms[7];
        r[7] = 1'b1;
        return r;
    endfunction

    // Bit 0 has the highest priority, so the lowest set index wins.
    function automatic logic [31:0] lowest_set_idx(input logic [INT_NUM-1:0] f);
        logic [31:0] idx;
        idx = 32'd0;
        for (int i = INT_NUM - 1; i >= 0; i--) begin
            if (f[i]) begin
                idx = i[31:0];
            end
        end
        return idx;
    endfunction

    logic [2:0]  state_r;
    logic        we_r;
    logic [11:0] waddr_r;
    logic [31:0] data_r;
    logic        assert_r;
    logic [31:0] addr_r;
    logic [31:0] cause_r;

    logic        is_ecall_s;
    logic        is_ebreak_s;
    logic        is_mret_s;
    logic        async_req_s;
    logic        trap_det_s;
    logic        mret_det_s;
    logic [31:0] cause_det_s;
    logic [31:0] epc_det_s;

    logic [2:0]  state_nxt_s;
    logic        we_nxt_s;
    logic [11:0] waddr_nxt_s;
    logic [31:0] data_nxt_s;
    logic        assert_nxt_s;
    logic [31:0] addr_nxt_s;

    assign is_ecall_s  = (inst_i == INST_ECALL);
    assign is_ebreak_s = (inst_i == INST_EBREAK);
    assign is_mret_s   = (inst_i == INST_MRET);
    assign async_req_s = (|int_flag_i) && csr_mstatus_i[3] && !ex_busy_i;

    // Event detection in IDLE with priority sync > MRET > async.
    always_comb begin
        trap_det_s  = 1'b0;
        mret_det_s  = 1'b0;
        cause_det_s = 32'd0;
        epc_det_s   = 32'd0;
        if (state_r == S_IDLE) begin
            if (is_ecall_s || is_ebreak_s) begin
                trap_det_s  = 1'b1;
                cause_det_s = is_ecall_s ? CAUSE_ECALL : CAUSE_EBREAK;
                epc_det_s   = inst_addr_i;
            end else if (is_mret_s) begin
                mret_det_s = 1'b1;
            end else if (async_req_s) begin
                trap_det_s  = 1'b1;
                cause_det_s = CAUSE_EXT + lowest_set_idx(int_flag_i);
                epc_det_s   = jump_flag_i ? jump_addr_i : inst_addr_i;
            end else begin
                trap_det_s = 1'b0;
            end
        end else begin
            trap_det_s = 1'b0;
        end
    end

    assign hold_flag_o = (state_r != S_IDLE) || trap_det_s || mret_det_s;

    // Next state and the output values that state will present.
    always_comb begin
        state_nxt_s  = S_IDLE;
        we_nxt_s     = 1'b0;
        waddr_nxt_s  = 12'd0;
        data_nxt_s   = 32'd0;
        assert_nxt_s = 1'b0;
        addr_nxt_s   = 32'd0;
        case (state_r)
            S_IDLE: begin
                if (trap_det_s) begin
                    state_nxt_s = S_W_MEPC;
                    we_nxt_s    = 1'b1;
                    waddr_nxt_s = CSR_MEPC;
                    data_nxt_s  = epc_det_s;
                end else if (mret_det_s) begin
                    state_nxt_s = S_R_MSTATUS;
                    we_nxt_s    = 1'b1;
                    waddr_nxt_s = CSR_MSTATUS;
                    data_nxt_s  = mstatus_on_ret(csr_mstatus_i);
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_W_MEPC: begin
                state_nxt_s = S_W_MCAUSE;
                we_nxt_s    = 1'b1;
                waddr_nxt_s = CSR_MCAUSE;
                data_nxt_s  = cause_r;
            end
            S_W_MCAUSE: begin
                state_nxt_s = S_W_MSTATUS;
                we_nxt_s    = 1'b1;
                waddr_nxt_s = CSR_MSTATUS;
                data_nxt_s  = mstatus_on_trap(csr_mstatus_i);
            end
            S_W_MSTATUS: begin
                state_nxt_s  = S_ASSERT;
                assert_nxt_s = 1'b1;
                addr_nxt_s   = csr_mtvec_i;
            end
            S_R_MSTATUS: begin
                state_nxt_s  = S_ASSERT;
                assert_nxt_s = 1'b1;
                addr_nxt_s   = csr_mepc_i;
            end
            S_ASSERT: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State and registered CSR/redirect outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= S_IDLE;
            we_r     <= 1'b0;
            waddr_r  <= 12'd0;
            data_r   <= 32'd0;
            assert_r <= 1'b0;
            addr_r   <= 32'd0;
        end else begin
            state_r  <= state_nxt_s;
            we_r     <= we_nxt_s;
            waddr_r  <= waddr_nxt_s;
            data_r   <= data_nxt_s;
            assert_r <= assert_nxt_s;
            addr_r   <= addr_nxt_s;
        end
    end

    // Cause is latched at detect so later input changes cannot disturb the sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause_r <= 32'd0;
        end else if (trap_det_s) begin
            cause_r <= cause_det_s;
        end else begin
            cause_r <= cause_r;
        end
    end

    assign we_o         = we_r;
    assign waddr_o      = waddr_r;
    assign data_o       = data_r;
    assign int_assert_o = assert_r;
    assign int_addr_o   = addr_r;

endmodule

// File: tb/tb_int_ctrl.sv
// Randomized and directed bench for int_ctrl against a sequence-level reference model.
module tb_int_ctrl;

    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  int_flag_i;
    logic [31:0] inst_i, inst_addr_i, jump_addr_i;
    logic        jump_flag_i, ex_busy_i;
    logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic        hold_flag_o, we_o, int_assert_o;
    logic [11:0] waddr_o;
    logic [31:0] data_o, int_addr_o;

    int n_cmp = 0;
    int n_err = 0;
    int hold_cnt, assert_cnt, we_cnt;

    typedef struct packed {
        logic        we;
        logic [11:0] waddr;
        logic [31:0] data;
        logic        as;
        logic [31:0] addr;
    } rec_t;

    rec_t exp_q[$];

    int_ctrl dut (
        .clk(clk), .rst(rst), .int_flag_i(int_flag_i), .inst_i(inst_i),
        .inst_addr_i(inst_addr_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .ex_busy_i(ex_busy_i), .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
        .csr_mstatus_i(csr_mstatus_i), .hold_flag_o(hold_flag_o), .we_o(we_o),
        .waddr_o(waddr_o), .data_o(data_o), .int_assert_o(int_assert_o),
        .int_addr_o(int_addr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic int lowest_bit(input logic [7:0] f);
        for (int i = 0; i < 8; i++) if (f[i]) return i;
        return 0;
    endfunction

    task automatic push_rec(input logic we, input logic [11:0] wa, input logic [31:0] d,
                            input logic as, input logic [31:0] ad);
        rec_t r;
        r.we = we; r.waddr = wa; r.data = d; r.as = as; r.addr = ad;
        exp_q.push_back(r);
    endtask

    // Checks one cycle (inputs already driven after the falling edge), then advances.
    task automatic run_cycle();
        rec_t e;
        logic exp_hold;
        logic [31:0] cause, epc, ms;
        int ev;
        #1;
        e = '0;
        exp_hold = 1'b0;
        if (rst) exp_q.delete();
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            exp_hold = 1'b1;
        end else begin
            ev = 0; cause = 32'd0; epc = 32'd0; ms = csr_mstatus_i;
            if (inst_i == ECALL) begin ev = 1; cause = 32'd11; epc = inst_addr_i; end
            else if (inst_i == EBREAK) begin ev = 1; cause = 32'd3; epc = inst_addr_i; end
            else if (inst_i == MRET) ev = 2;
            else if ((int_flag_i != 8'd0) && ms[3] && !ex_busy_i) begin
                ev = 1;
                cause = 32'h8000_0010 + lowest_bit(int_flag_i);
                epc = jump_flag_i ? jump_addr_i : inst_addr_i;
            end
            exp_hold = (ev != 0);
            if (!rst && ev == 1) begin
                push_rec(1'b1, 12'h341, epc, 1'b0, 32'd0);
                push_rec(1'b1, 12'h342, cause, 1'b0, 32'd0);
                push_rec(1'b1, 12'h300, (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0), 1'b0, 32'd0);
                push_rec(1'b0, 12'h000, 32'd0, 1'b1, csr_mtvec_i);
            end else if (!rst && ev == 2) begin
                push_rec(1'b1, 12'h300, (ms & ~32'h88) | 32'h80 | (ms[7] ? 32'h8 : 32'h0), 1'b0, 32'd0);
                push_rec(1'b0, 12'h000, 32'd0, 1'b1, csr_mepc_i);
            end
        end
        check("hold_flag", {31'd0, hold_flag_o}, {31'd0, exp_hold});
        check("we", {31'd0, we_o}, {31'd0, e.we});
        check("waddr", {20'd0, waddr_o}, {20'd0, e.waddr});
        check("data", data_o, e.data);
        check("int_assert", {31'd0, int_assert_o}, {31'd0, e.as});
        check("int_addr", int_addr_o, e.addr);
        hold_cnt   += int'(hold_flag_o);
        assert_cnt += int'(int_assert_o);
        we_cnt     += int'(we_o);
        @(negedge clk);
    endtask

    task automatic quiet();
        inst_i = NOP; int_flag_i = 8'd0; jump_flag_i = 1'b0; ex_busy_i = 1'b0;
    endtask

    task automatic clr_cnt();
        hold_cnt = 0; assert_cnt = 0; we_cnt = 0;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        rst = 1'b1; quiet();
        inst_addr_i = 32'd0; jump_addr_i = 32'd0;
        csr_mtvec_i = 32'd0; csr_mepc_i = 32'd0; csr_mstatus_i = 32'd0;
        clr_cnt();
        @(negedge clk);
        run_n(2);
        rst = 1'b0;
        run_n(2);

        // ECALL at 0x100, mtvec 0x200, MIE=1
        csr_mtvec_i = 32'h200; csr_mstatus_i = 32'h8; inst_addr_i = 32'h100; inst_i = ECALL;
        clr_cnt(); run_cycle(); quiet(); run_n(6);
        check("ecall_hold_cycles", hold_cnt, 5);
        check("ecall_assert_cycles", assert_cnt, 1);
        check("ecall_writes", we_cnt, 3);

        // MRET with mepc 0x104, mstatus 0x80
        csr_mepc_i = 32'h104; csr_mstatus_i = 32'h80; inst_i = MRET;
        clr_cnt(); run_cycle(); quiet(); run_n(4);
        check("mret_hold_cycles", hold_cnt, 3);
        check("mret_writes", we_cnt, 1);

        // External line 2 during a redirect to 0x300
        csr_mstatus_i = 32'h8; int_flag_i = 8'b0000_0100; jump_flag_i = 1'b1; jump_addr_i = 32'h300;
        clr_cnt(); run_cycle(); quiet(); run_n(5);
        check("irq_hold_cycles", hold_cnt, 5);

        // Interrupt masked by MIE=0
        csr_mstatus_i = 32'h0; int_flag_i = 8'h01;
        clr_cnt(); run_n(4);
        check("masked_hold", hold_cnt, 0);
        check("masked_writes", we_cnt, 0);

        // Pending while ex busy, taken once busy drops
        csr_mstatus_i = 32'h8; ex_busy_i = 1'b1;
        clr_cnt(); run_n(3);
        check("busy_hold", hold_cnt, 0);
        ex_busy_i = 1'b0; run_cycle(); int_flag_i = 8'd0; run_n(5);
        check("busy_release_hold", hold_cnt, 5);

        // ECALL and interrupt together: ECALL first, interrupt after one IDLE cycle
        inst_i = ECALL; inst_addr_i = 32'h180; int_flag_i = 8'h01;
        clr_cnt(); run_cycle(); inst_i = NOP; run_n(4);
        check("ecall_first_hold", hold_cnt, 5);
        run_n(4); int_flag_i = 8'd0; run_n(3);
        check("irq_after_ecall_writes", we_cnt, 6);

        // Reset in W_MCAUSE aborts the sequence
        inst_i = ECALL; inst_addr_i = 32'h40;
        run_cycle(); quiet(); run_cycle();
        rst = 1'b1; clr_cnt(); run_n(2);
        rst = 1'b0; run_n(4);
        check("rst_abort_writes", we_cnt, 0);
        check("rst_abort_hold", hold_cnt, 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            if (exp_q.size() == 0) begin
                csr_mtvec_i   = $urandom & 32'hffff_fffc;
                csr_mepc_i    = $urandom & 32'hffff_fffc;
                csr_mstatus_i = $urandom;
            end
            r = $urandom_range(0, 15);
            inst_i = (r == 0) ? ECALL : (r == 1) ? EBREAK : (r == 2) ? MRET :
                     (r < 8) ? NOP : $urandom;
            inst_addr_i = $urandom & 32'hffff_fffc;
            jump_addr_i = $urandom & 32'hffff_fffc;
            jump_flag_i = ($urandom_range(0, 3) == 0);
            ex_busy_i   = ($urandom_range(0, 3) == 0);
            int_flag_i  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'd0;
            rst         = ($urandom_range(0, 199) == 0);
            run_cycle();
        end
        rst = 1'b0; quiet(); run_n(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
